double_tokens: RTL and testbench

DOUBLE_TOKENS -- requirements
Module: double_tokens

---
 rtl/double_tokens_pkg.sv | 11 +
 rtl/double_tokens.sv | 61 ++++++
 tb/tb_double_tokens.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/double_tokens_pkg.sv
// Shared constants and helpers for the token doubler.
package double_tokens_pkg;

    localparam int unsigned MAX_PENDING_DEFAULT = 15;

    // Width needed to hold every count from 0 up to max_pending inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_pending);
        return $clog2(max_pending + 1);
    endfunction

endpackage

// File: rtl/double_tokens.sv
// Token doubler: every accepted input strobe owes two output strobes, which
// are paid out one per cycle from a saturating pending counter.
module double_tokens
    import double_tokens_pkg::*;
#(
    parameter int unsigned MAX_PENDING = MAX_PENDING_DEFAULT
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                a,
    output logic                                a_ready,
    output logic                                b,
    output logic [cnt_width(MAX_PENDING)-1:0]   pending,
    output logic                                dropped
);

    localparam int unsigned CW = cnt_width(MAX_PENDING);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [CW:0]   cnt_sum;
    logic          accepted;

    // Outputs depend on registered state only, so a never reaches b.
    assign a_ready  = ({1'b0, cnt} < (CW+1)'(MAX_PENDING));
    assign b        = (cnt != '0);
    assign pending  = cnt;
    assign accepted = a & a_ready;

    // One extra bit keeps cnt + 2 from wrapping before the emit is subtracted.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cnt_sum  = {1'b0, cnt};
        cnt_next = cnt;
        if (accepted) begin
            cnt_sum = cnt_sum + (CW+1)'(2);
        end
        if (b) begin
            cnt_sum = cnt_sum - (CW+1)'(1);
        end
        cnt_next = cnt_sum[CW-1:0];
    end

    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dropped <= 1'b0;
        end else if (a && !a_ready) begin
            dropped <= 1'b1;
        end
    end

endmodule

// File: tb/tb_double_tokens.sv
// Randomized and directed bench for double_tokens against an owed-token model.
module tb_double_tokens;
    import double_tokens_pkg::*;

    localparam int unsigned MAXP = MAX_PENDING_DEFAULT;
    localparam int unsigned CW   = cnt_width(MAXP);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          a   = 1'b0;
    logic          a_ready;
    logic          b;
    logic [CW-1:0] pending;
    logic          dropped;

    int checks = 0;
    int errors = 0;

    // Reference model: number of owed tokens and sticky drop flag.
    int   m_cnt  = 0;
    bit   m_drop = 0;
    int   m_acc  = 0;

    // Values seen and expected just before the most recent edge.
    logic obs_b, obs_ready, obs_drop;
    int   obs_pending;
    logic exp_b, exp_ready, exp_drop;
    int   exp_pending;
    int   dut_b_total   = 0;
    int   dut_acc_total = 0;

    double_tokens #(.MAX_PENDING(MAXP)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .a_ready (a_ready),
        .b       (b),
        .pending (pending),
        .dropped (dropped)
    );

    always #5 clk = ~clk;

    // Drive one cycle from a negedge, sample mid-cycle, advance model, end on next negedge.
    task automatic tick(input logic av);
        int acc;
        a = av;
        #1;
        obs_b       = b;
        obs_ready   = a_ready;
        obs_pending = int'(pending);
        obs_drop    = dropped;
        exp_b       = (m_cnt > 0);
        exp_ready   = (m_cnt < int'(MAXP));
        exp_pending = m_cnt;
        exp_drop    = m_drop;
        dut_b_total   += int'(obs_b);
        dut_acc_total += int'(av && obs_ready);
        acc = (av && exp_ready) ? 1 : 0;
        m_acc += acc;
        if (av && !exp_ready) m_drop = 1;
        m_cnt = m_cnt + 2 * acc - (exp_b ? 1 : 0);
        @(negedge clk);
    endtask

    // Assert reset mid-cycle, hold two cycles, release on a negedge.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        m_cnt  = 0;
        m_drop = 0;
        m_acc  = 0;
        dut_b_total   = 0;
        dut_acc_total = 0;
        @(negedge clk);
        @(negedge clk);
        a   = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (pending !== '0 || b !== 1'b0 || dropped !== 1'b0 || a_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got pending=%0d b=%0b dropped=%0b a_ready=%0b, want 0 0 0 1",
                     pending, b, dropped, a_ready);
        end
        rst = 1'b1;
    endtask

    task automatic test_single();
        int want_p [4] = '{0, 2, 1, 0};
        logic want_b [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(i == 0);
            checks++;
            if (obs_pending !== want_p[i] || obs_b !== want_b[i]) begin
                errors++;
                $display("FAIL single cycle N+%0d: got pending=%0d b=%0b, want pending=%0d b=%0b",
                         i, obs_pending, obs_b, want_p[i], want_b[i]);
            end
        end
    endtask

    task automatic test_saturate();
        int not_ready_mask = 0;
        int drain = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick(1'b1);
            if (!obs_ready) not_ready_mask |= (1 << i);
            checks++;
            if (obs_pending !== exp_pending || obs_ready !== exp_ready || obs_b !== exp_b) begin
                errors++;
                $display("FAIL saturate cycle %0d: got p=%0d r=%0b b=%0b, want p=%0d r=%0b b=%0b",
                         i, obs_pending, obs_ready, obs_b, exp_pending, exp_ready, exp_b);
            end
            if (i == 15) begin
                checks++;
                if (obs_drop !== 1'b1) begin
                    errors++;
                    $display("FAIL saturate dropped@15: got %0b, want 1", obs_drop);
                end
            end
        end
        checks++;
        if (not_ready_mask !== ((1 << 14) | (1 << 16) | (1 << 18))) begin
            errors++;
            $display("FAIL saturate ready_mask: got %h, want %h", not_ready_mask,
                     (1 << 14) | (1 << 16) | (1 << 18));
        end
        checks++;
        if (dut_acc_total !== 17) begin
            errors++;
            $display("FAIL saturate accepted: got %0d, want 17", dut_acc_total);
        end
        while (pending != '0 && drain < 40) begin
            tick(1'b0);
            drain++;
        end
        tick(1'b0);
        checks++;
        if (dut_b_total !== 34 || obs_pending !== 0) begin
            errors++;
            $display("FAIL saturate drain: got b_total=%0d pending=%0d, want 34 0",
                     dut_b_total, obs_pending);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (dropped !== 1'b0) begin
            errors++;
            $display("FAIL saturate dropped_clear: got %0b, want 0", dropped);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            tick((i < 100) ? 1'($urandom_range(0, 1)) : 1'b0);
            if (obs_pending !== exp_pending || obs_ready !== exp_ready ||
                obs_b !== exp_b || obs_drop !== exp_drop) begin
                if (bad == 0)
                    $display("FAIL random cycle %0d: got p=%0d r=%0b b=%0b d=%0b, want p=%0d r=%0b b=%0b d=%0b",
                             i, obs_pending, obs_ready, obs_b, obs_drop,
                             exp_pending, exp_ready, exp_b, exp_drop);
                bad++;
            end
        end
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (dut_b_total !== 2 * m_acc || obs_pending !== 0 || dropped !== m_drop) begin
            errors++;
            $display("FAIL random totals: got b=%0d pending=%0d dropped=%0b, want b=%0d pending=0 dropped=%0b",
                     dut_b_total, obs_pending, dropped, 2 * m_acc, m_drop);
        end
    endtask

    task automatic test_async_reset();
        int late_b = 0;
        do_reset();
        for (int i = 0; i < 6; i++) tick(1'b1);
        checks++;
        if (pending !== CW'(7)) begin
            errors++;
            $display("FAIL async_load: got pending=%0d, want 7", pending);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (b !== 1'b0 || pending !== '0 || dropped !== 1'b0 || a_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_clear: got b=%0b pending=%0d dropped=%0b a_ready=%0b, want 0 0 0 1",
                     b, pending, dropped, a_ready);
        end
        m_cnt = 0;
        m_drop = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0);
            late_b += int'(obs_b);
        end
        checks++;
        if (late_b !== 0) begin
            errors++;
            $display("FAIL async_no_late_b: got %0d tokens, want 0", late_b);
        end
    endtask

    task automatic test_reset_hold();
        int leak = 0;
        do_reset();
        #2;
        rst = 1'b0;
        a   = 1'b1;
        m_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (pending !== '0) leak++;
        end
        a   = 1'b0;
        rst = 1'b1;
        tick(1'b0);
        #1;
        checks++;
        if (leak !== 0 || pending !== '0) begin
            errors++;
            $display("FAIL reset_hold: got leak_cycles=%0d pending=%0d, want 0 0", leak, pending);
        end
        @(negedge clk);
        tick(1'b1);
        #1;
        checks++;
        if (pending !== CW'(2)) begin
            errors++;
            $display("FAIL reset_first_accept: got pending=%0d, want 2", pending);
        end
        @(negedge clk);
    endtask

    task automatic test_alternate();
        int low_ready = 0;
        int max_p = 0;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            tick((i % 2) == 0);
            if (!obs_ready) low_ready++;
            if (obs_pending > max_p) max_p = obs_pending;
        end
        for (int i = 0; i < 5; i++) tick(1'b0);
        checks++;
        if (low_ready !== 0 || max_p > 2 || max_p < 2) begin
            errors++;
            $display("FAIL alternate bounds: got low_ready=%0d max_pending=%0d, want 0 2",
                     low_ready, max_p);
        end
        checks++;
        if (dut_b_total !== 40 || obs_pending !== 0) begin
            errors++;
            $display("FAIL alternate total: got b=%0d pending=%0d, want 40 0",
                     dut_b_total, obs_pending);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_saturate();
        test_random();
        test_async_reset();
        test_reset_hold();
        test_alternate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

endmodule
